lfsr_word_gen: RTL and testbench

Parametrised Fibonacci LFSR pseudo-random word generator for the fetal ECG datapath. It supplies dither and synthetic-noise words to the test-signal and filter-verification paths. Width, tap polynomial, output word width and shifts-per-word are set at elaboration; the seed is run-time loadable. Words are delivered over a valid/ready handshake, and the generator stalls rather than drop a word, so the output sequence is fully deterministic for a given seed.

---
 rtl/lfsr_word_gen.sv | 89 ++++++++
 tb/tb_lfsr_word_gen.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_word_gen.sv
// Fibonacci LFSR word generator. The state shifts SHIFTS times per output word.
// Words go out through a one-entry output register with a valid/ready handshake.
//
// Handshake: out_valid stays high with out_data frozen until the consumer raises
// out_ready. A word transfers on any rising edge where out_valid && out_ready.
// When a word is due and the register is still occupied, the generator stalls
// (no shift) rather than drop the word. This keeps the sequence deterministic
// for a given seed.
module lfsr_word_gen #(
  parameter int               WIDTH      = 52,
  parameter logic [WIDTH-1:0] TAPS       = 52'h9000000000000,
  parameter int               OUT_W      = 16,
  parameter int               SHIFTS     = 16,
  parameter logic [WIDTH-1:0] RESET_SEED = 52'h1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             stalled,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } ctrl_e;

  localparam logic [15:0]      LAST = 16'(SHIFTS - 1);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] state_nxt;
  logic [15:0]      cnt;
  logic             fb;
  logic             due;
  logic             accept;
  ctrl_e            ctrl;

  // Next LFSR state, including the all-zero lock-up guard, and the control decode.
  always_comb begin
    fb        = ^(state & TAPS);
    state_nxt = (state == '0) ? ONE : {state[WIDTH-2:0], fb};
    due       = (cnt == LAST);
    accept    = out_valid && out_ready;
    if (!en) begin
      ctrl = IDLE;
    end else if (due && out_valid && !out_ready) begin
      ctrl = STALL;
    end else begin
      ctrl = RUN;
    end
    stalled   = (ctrl == STALL);
    dbg_state = ctrl;
  end

  // State, shift counter and output register.
  // Priority order: reset, then seed load, then shifting and handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RESET_SEED;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (seed_load) begin
      state     <= (seed == '0) ? ONE : seed;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else if (ctrl == RUN) begin
      state <= state_nxt;
      if (due) begin
        cnt       <= '0;
        out_data  <= state_nxt[OUT_W-1:0];
        out_valid <= 1'b1;
      end else begin
        cnt <= cnt + 16'd1;
        if (accept) out_valid <= 1'b0;
      end
    end else if (accept) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lfsr_word_gen.sv
// Bench for lfsr_word_gen. It uses three instances:
//   u_a: 4-bit, x^4+x+1, SHIFTS=1, RESET_SEED=5 -- sequence, backpressure, seed load, reset
//   u_b: 4-bit, SHIFTS=4 -- latency, spacing and stall on a due word
//   u_c: defaults -- random en/out_ready against a polynomial word model
module tb_lfsr_word_gen;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        en_a = 0, sl_a = 0, rdy_a = 0;
  logic [3:0]  seed_a = 0;
  logic [3:0]  data_a;
  logic        val_a, stl_a;
  logic [1:0]  dbg_a;

  logic        en_b = 0, sl_b = 0, rdy_b = 0;
  logic [3:0]  seed_b = 0;
  logic [3:0]  data_b;
  logic        val_b, stl_b;
  logic [1:0]  dbg_b;

  logic        en_c = 0, sl_c = 0, rdy_c = 0;
  logic [51:0] seed_c = 0;
  logic [15:0] data_c;
  logic        val_c, stl_c;
  logic [1:0]  dbg_c;

  lfsr_word_gen #(.WIDTH(4), .TAPS(4'b1001), .OUT_W(4), .SHIFTS(1), .RESET_SEED(4'd5)) u_a (
    .clk(clk), .reset(reset), .en(en_a), .seed_load(sl_a), .seed(seed_a),
    .out_data(data_a), .out_valid(val_a), .out_ready(rdy_a), .stalled(stl_a),
    .dbg_state(dbg_a));

  lfsr_word_gen #(.WIDTH(4), .TAPS(4'b1001), .OUT_W(4), .SHIFTS(4), .RESET_SEED(4'd1)) u_b (
    .clk(clk), .reset(reset), .en(en_b), .seed_load(sl_b), .seed(seed_b),
    .out_data(data_b), .out_valid(val_b), .out_ready(rdy_b), .stalled(stl_b),
    .dbg_state(dbg_b));

  lfsr_word_gen u_c (
    .clk(clk), .reset(reset), .en(en_c), .seed_load(sl_c), .seed(seed_c),
    .out_data(data_c), .out_valid(val_c), .out_ready(rdy_c), .stalled(stl_c),
    .dbg_state(dbg_c));

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] exp_q[$];
  logic [3:0]  seq4[15];

  // Scoreboard compare.
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One shift of x^52 + x^49 + 1: the new bit is the XOR of the x^52 and x^49 stages.
  function automatic logic [51:0] step52(input logic [51:0] s);
    return {s[50:0], s[51] ^ s[48]};
  endfunction

  initial begin
    logic [51:0] s;
    logic        prev_hold;
    logic [15:0] prev_data;
    int          cycles;
    logic [15:0] exp_w;

    seq4 = '{4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hA, 4'h5, 4'hB,
             4'h6, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8, 4'h1};

    // ---- reset state ----
    tick(); tick();
    reset = 0;
    check("a_rst_valid", 64'(val_a), 0);
    check("a_rst_data", 64'(data_a), 0);
    check("a_rst_stalled", 64'(stl_a), 0);

    // ---- Case 1: SHIFTS=1, seed 1, full throughput ----
    sl_a = 1; seed_a = 4'd1;
    tick();
    sl_a = 0; en_a = 1; rdy_a = 1;
    for (int k = 0; k < 30; k++) begin
      tick();
      check("c1_valid", 64'(val_a), 1);
      check("c1_word", 64'(data_a), 64'(seq4[k % 15]));
    end

    // ---- backpressure ----
    sl_a = 1; seed_a = 4'd1;
    tick();
    sl_a = 0;
    check("bp_reload_valid", 64'(val_a), 0);
    tick();
    check("bp_first", 64'(data_a), 64'h3);
    rdy_a = 0;
    #1;
    check("bp_stalled_on", 64'(stl_a), 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_hold_data", 64'(data_a), 64'h3);
      check("bp_hold_valid", 64'(val_a), 1);
      check("bp_hold_stalled", 64'(stl_a), 1);
    end
    rdy_a = 1;
    #1;
    check("bp_stalled_off", 64'(stl_a), 0);
    for (int k = 1; k < 4; k++) begin
      tick();
      check("bp_resume", 64'(data_a), 64'(seq4[k]));
    end

    // ---- seed load (seed 0) while a word is pending ----
    rdy_a = 0;
    tick();
    check("sl_pending", 64'(data_a), 64'hE);
    sl_a = 1; seed_a = 4'd0;
    tick();
    sl_a = 0;
    check("sl_valid_drop", 64'(val_a), 0);
    rdy_a = 1;
    tick();
    check("sl_word0", 64'(data_a), 64'h3);
    tick();
    check("sl_word1", 64'(data_a), 64'h7);

    // ---- reset mid-stall, RESET_SEED=5 ----
    rdy_a = 0;
    tick();
    check("rs_stalled", 64'(stl_a), 1);
    reset = 1;
    tick();
    check("rs_valid", 64'(val_a), 0);
    check("rs_data", 64'(data_a), 0);
    check("rs_stalled_clr", 64'(stl_a), 0);
    reset = 0; rdy_a = 1;
    tick();
    check("rs_word0", 64'(data_a), 64'hB);
    tick();
    check("rs_word1", 64'(data_a), 64'h6);

    // ---- draining with en=0 ----
    en_a = 0;
    tick();
    check("drain_valid", 64'(val_a), 0);
    check("drain_data", 64'(data_a), 64'h6);
    tick();
    check("idle_valid", 64'(val_a), 0);
    en_a = 1;
    tick();
    check("idle_resume", 64'(data_a), 64'hC);
    en_a = 0;

    // ---- Case 2: SHIFTS=4 latency and spacing ----
    reset = 1;
    tick();
    reset = 0; en_b = 1; rdy_b = 1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      check("c2_valid", 64'(val_b), 64'(e % 4 == 0));
      if (e % 4 == 0) check("c2_word", 64'(data_b), 64'(seq4[e - 1]));
    end
    rdy_b = 0;
    tick();
    check("c2_shift_stalled", 64'(stl_b), 0);
    check("c2_shift_data", 64'(data_b), 64'h2);
    tick(); tick();
    check("c2_due_stalled", 64'(stl_b), 1);
    tick();
    check("c2_due_hold", 64'(data_b), 64'h2);
    rdy_b = 1;
    #1;
    check("c2_release", 64'(stl_b), 0);
    tick();
    check("c2_after_stall", 64'(data_b), 64'h3);
    check("c2_after_valid", 64'(val_b), 1);
    en_b = 0;

    // ---- defaults: random en/out_ready against the polynomial model ----
    reset = 1;
    tick();
    reset = 0;
    check("c_rst_valid", 64'(val_c), 0);
    check("c_rst_data", 64'(data_c), 0);
    s = 52'h1;
    for (int w = 0; w < 1200; w++) begin
      for (int k = 0; k < 16; k++) s = step52(s);
      exp_q.push_back(s[15:0]);
    end
    prev_hold = 0;
    prev_data = '0;
    cycles = 0;
    while (exp_q.size() > 0 && cycles < 60000) begin
      en_c  = ($urandom_range(0, 7) != 0);
      rdy_c = ($urandom_range(0, 1) == 1);
      #1;
      if (prev_hold) begin
        check("rnd_hold_valid", 64'(val_c), 1);
        check("rnd_hold_data", 64'(data_c), 64'(prev_data));
      end
      if (val_c && rdy_c) begin
        exp_w = exp_q.pop_front();
        check("rnd_word", 64'(data_c), 64'(exp_w));
      end
      prev_hold = val_c && !rdy_c;
      prev_data = data_c;
      tick();
      cycles++;
    end
    check("rnd_timeout_left", 64'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
